// File: rtl/ps4_pkg.sv
// Shared types and helpers for the 4-way req/en -> gnt requester.
package ps4_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {ARB = 1'b0, XFER = 1'b1} req_state_t;

  typedef logic [1:0] ch_idx_t;

  function automatic logic is_onehot(input logic [NUM_CH-1:0] v);
    return (v != '0) && ((v & (v - NUM_CH'(1))) == '0);
  endfunction

  function automatic ch_idx_t onehot_to_idx(input logic [NUM_CH-1:0] v);
    ch_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i]) idx = ch_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ps4_pend_ctr.sv
// Saturating pending-job counter for one channel, with a sticky drop flag.
module ps4_pend_ctr
  import ps4_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // A push and a grant in the same cycle cancel, so saturation only drops pure pushes.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/ps4_requester.sv
// Initiator for a 4-way priority selector: queues jobs per channel, requests,
// and runs a fixed-length transfer for each granted channel.
module ps4_requester
  import ps4_pkg::*;
#(
  parameter int CNT_W    = 3,
  parameter int XFER_LEN = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] push,
  input  logic [NUM_CH-1:0] gnt,
  output logic [NUM_CH-1:0] req,
  output logic              en,
  output logic              xfer_valid,
  output ch_idx_t           xfer_ch,
  output logic              xfer_last,
  output logic              busy,
  output logic [NUM_CH-1:0] overflow,
  output logic              err_gnt
);

  localparam int BEAT_W = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(XFER_LEN - 1);

  req_state_t  state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  ch_idx_t     ch_q, ch_d;
  logic        err_q, err_d;

  logic [NUM_CH-1:0][CNT_W-1:0] pend;
  logic [NUM_CH-1:0]            req_arb;
  logic [NUM_CH-1:0]            dec;
  logic                         en_arb;
  logic                         grant_ok;
  logic                         gnt_bad;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ps4_pend_ctr #(.CNT_W(CNT_W)) u_pend (
      .clock  (clock),
      .reset_n(reset_n),
      .inc_i  (push[i]),
      .dec_i  (dec[i]),
      .cnt_o  (pend[i]),
      .ovf_o  (overflow[i])
    );
    assign req_arb[i] = (pend[i] != '0);
  end

  assign en_arb = |req_arb;

  // gnt only means something while we are actually enabling the selector.
  assign grant_ok = (state_q == ARB) && en_arb && is_onehot(gnt) && ((gnt & req_arb) != '0);
  assign gnt_bad  = (state_q == ARB) && en_arb && (gnt != '0) && !grant_ok;
  assign dec      = grant_ok ? gnt : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB;
      beat_q  <= '0;
      ch_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ch_d    = ch_q;
    err_d   = err_q | gnt_bad;
    unique case (state_q)
      ARB: begin
        if (grant_ok) begin
          state_d = XFER;
          ch_d    = onehot_to_idx(gnt);
          beat_d  = '0;
        end
      end
      XFER: begin
        // Straight back to ARB after the last beat, no idle cycle.
        if (beat_q == LAST_BEAT) begin
          state_d = ARB;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    req        = '0;
    en         = 1'b0;
    busy       = 1'b0;
    xfer_valid = 1'b0;
    xfer_ch    = '0;
    xfer_last  = 1'b0;
    unique case (state_q)
      ARB: begin
        req = req_arb;
        en  = en_arb;
      end
      XFER: begin
        busy       = 1'b1;
        xfer_valid = 1'b1;
        xfer_ch    = ch_q;
        xfer_last  = (beat_q == LAST_BEAT);
      end
    endcase
  end

  assign err_gnt = err_q;

endmodule

// File: tb/tb_ps4_requester.sv
// Directed bench for ps4_requester with a fixed-priority selector model (req[0] highest).
module tb_ps4_requester;
  import ps4_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  push;
  logic [3:0]  gnt;
  logic [3:0]  req;
  logic        en;
  logic        xfer_valid;
  ch_idx_t     xfer_ch;
  logic        xfer_last;
  logic        busy;
  logic [3:0]  overflow;
  logic        err_gnt;

  logic        sel_on;
  logic        frc_on;
  logic [3:0]  frc_gnt;

  int errors = 0;
  int checks = 0;

  ps4_requester #(.CNT_W(3), .XFER_LEN(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .gnt       (gnt),
    .req       (req),
    .en        (en),
    .xfer_valid(xfer_valid),
    .xfer_ch   (xfer_ch),
    .xfer_last (xfer_last),
    .busy      (busy),
    .overflow  (overflow),
    .err_gnt   (err_gnt)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] prio(input logic [3:0] r);
    logic [3:0] g;
    g = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) g = 4'(1 << i);
    end
    return g;
  endfunction

  assign gnt = frc_on ? frc_gnt : ((sel_on && en) ? prio(req) : 4'b0000);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    push    = 4'b0000;
    frc_on  = 1'b0;
    frc_gnt = 4'b0000;
    sel_on  = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int beats;
    int viol;
    int n;
    ch_idx_t order [3];

    reset_n = 1'b0;
    do_reset();

    // Reset state
    check_eq("rst_req", req, 4'b0000);
    check_eq("rst_en", en, 1'b0);
    check_eq("rst_valid", xfer_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ovf", overflow, 4'b0000);
    check_eq("rst_err", err_gnt, 1'b0);

    // Test 1: single job on ch2
    sel_on = 1'b1;
    push   = 4'b0100;
    tick();
    push   = 4'b0000;
    check_eq("t1_req", req, 4'b0100);
    check_eq("t1_en", en, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_valid", xfer_valid, 1'b1);
      check_eq("t1_ch", xfer_ch, 2'd2);
      check_eq("t1_last", xfer_last, (i == 3) ? 1'b1 : 1'b0);
      check_eq("t1_busy", busy, 1'b1);
      check_eq("t1_xreq", req, 4'b0000);
      if (i == 0) check_eq("t1_pend2", dut.pend[2], 3'd0);
      tick();
    end
    check_eq("t1_done_valid", xfer_valid, 1'b0);
    check_eq("t1_done_req", req, 4'b0000);

    // Test 2: ch0 twice, ch3 once, in priority order
    do_reset();
    sel_on = 1'b1;
    push   = 4'b1001;
    tick();
    push   = 4'b0001;
    tick();
    push   = 4'b0000;
    beats = 0;
    viol  = 0;
    n     = 0;
    for (int c = 0; c < 20; c++) begin
      if (xfer_valid) beats++;
      if (busy && (req != 4'b0000)) viol++;
      if (xfer_last && (n < 3)) begin
        order[n] = xfer_ch;
        n++;
      end
      tick();
    end
    check_eq("t2_beats", beats, 12);
    check_eq("t2_xfers", n, 3);
    check_eq("t2_order0", order[0], 2'd0);
    check_eq("t2_order1", order[1], 2'd0);
    check_eq("t2_order2", order[2], 2'd3);
    check_eq("t2_req_in_xfer", viol, 0);
    check_eq("t2_idle_req", req, 4'b0000);

    // Test 3: nine pushes to ch1 with no grants
    do_reset();
    push = 4'b0010;
    repeat (9) tick();
    push = 4'b0000;
    check_eq("t3_pend1", dut.pend[1], 3'd7);
    check_eq("t3_ovf", overflow, 4'b0010);
    check_eq("t3_req", req, 4'b0010);

    // Test 4: saturated ch1 with simultaneous push and grant
    do_reset();
    push = 4'b0010;
    repeat (7) tick();
    check_eq("t4_pre_pend1", dut.pend[1], 3'd7);
    check_eq("t4_pre_ovf", overflow, 4'b0000);
    sel_on = 1'b1;
    tick();
    push   = 4'b0000;
    sel_on = 1'b0;
    check_eq("t4_pend1", dut.pend[1], 3'd7);
    check_eq("t4_ovf", overflow, 4'b0000);
    check_eq("t4_xfer", xfer_valid, 1'b1);
    check_eq("t4_ch", xfer_ch, 2'd1);

    // Test 5: illegal two-hot grant
    do_reset();
    push = 4'b0011;
    tick();
    push = 4'b0000;
    check_eq("t5_req", req, 4'b0011);
    frc_on  = 1'b1;
    frc_gnt = 4'b0011;
    tick();
    frc_on  = 1'b0;
    check_eq("t5_err", err_gnt, 1'b1);
    check_eq("t5_state", dut.state_q, ARB);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_pend0", dut.pend[0], 3'd1);
    check_eq("t5_pend1", dut.pend[1], 3'd1);

    // Test 6: asynchronous reset on the second beat
    do_reset();
    sel_on = 1'b1;
    push   = 4'b0100;
    tick();
    push   = 4'b0000;
    tick();
    tick();
    check_eq("t6_beat2_valid", xfer_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_valid", xfer_valid, 1'b0);
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_req", req, 4'b0000);
    check_eq("t6_en", en, 1'b0);
    check_eq("t6_ch", xfer_ch, 2'd0);
    check_eq("t6_last", xfer_last, 1'b0);
    check_eq("t6_ovf", overflow, 4'b0000);
    check_eq("t6_err", err_gnt, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    check_eq("t6_state", dut.state_q, ARB);
    check_eq("t6_post_valid", xfer_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("t6_pend", dut.pend[i], 3'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
